noc_input_port: RTL
===================

Name: noc_input_port

Overview:
- Per-direction input stage of the 5-port router (L, N, E, W, S). One instance sits in front of each switch input.
- Buffers incoming flits from the neighbouring router or local core in a small FIFO.
- Computes the XY route of the head flit and drives the switch's In_x data bus and request_x code. Holds the request until the switch's grant_x, then pops.
- Drives full back upstream for flow control.

Parameters:
- DATA_W, 8, flit width. Must match the switch data width.
- DEPTH, 4, FIFO depth in flits (power of 2, >=2).
- X_CUR, 1, this router's X coordinate (2-bit).
- Y_CUR, 1, this router's Y coordinate (2-bit).

Ports:
- clk  in  1  Single clock. All state updates on rising edge.
- rst  in  1  Asynchronous, active-low reset (0 = reset).
- data_in  in  DATA_W  Flit from upstream.
- valid_in  in  1  Upstream write strobe. Sampled at rising edge.
- full  out  1  FIFO full, to upstream. Upstream must not assert valid_in while full=1.
- data_out  out  DATA_W  Head flit to switch In_x.
- request  out  3  Route code to switch request_x.
- grant  in  1  Switch grant_x for this port.
- count  out  log2(DEPTH)+1  FIFO occupancy (debug/verification).

Behaviour:
- Flit format: dest_x = flit[7:6], dest_y = flit[5:4]. Bits [3:0] are payload.
- Request encoding: 0 = L, 1 = N, 2 = E, 3 = S, 4 = W, 7 = no request. Codes 5 and 6 are never driven.
- XY routing, X resolved first:
  - dest_x > X_CUR -> E (2).
  - dest_x < X_CUR -> W (4).
  - Otherwise dest_y > Y_CUR -> S (3).
  - Otherwise dest_y < Y_CUR -> N (1).
  - Otherwise L (0).
- Reset (rst=0, asynchronous): request = 3'b111, data_out = 0, full = 0, count = 0, pointers = 0, state = IDLE. FIFO contents are don't-care.
- FIFO:
  - Write occurs when valid_in=1 and full=0 at the edge. valid_in while full=1 is ignored; the flit is dropped and count is unchanged.
  - full = (count == DEPTH), registered from next-count.
  - Pointers wrap modulo DEPTH.
  - A push and a pop at the same edge leave count unchanged.
- FSM, two states:
  - IDLE: request = 7. If count > 0 at the edge, load the head flit into data_out, load its route code into request, and go to REQ. grant is ignored in IDLE.
  - REQ: data_out and request are held stable until grant=1 is sampled at an edge. On that edge the FIFO pops.
    - If count after the pop and any same-edge push is > 0, load the next head and stay in REQ (back-to-back, 1 flit/clk).
    - Otherwise set request = 7 and go to IDLE.
- Latency: a flit written at edge N into an empty FIFO in IDLE appears on request/data_out after edge N+1.
- A write into an empty FIFO on the same edge that pops the last flit goes IDLE, and the new flit is presented one edge later.
- The switch deasserting grant for back-pressure (its full_x) simply holds REQ. There is no timeout.
- Reset asserted mid-packet: all buffered flits are discarded, request goes to 7 immediately (asynchronously), and full is cleared.

Test Plan:
- Reset check: hold rst=0 with valid_in=1 and data_in=0x9A -> request=7, full=0, count=0. Release rst, write nothing -> request stays 7.
- Routing, X_CUR=1, Y_CUR=1, grant held 1: write 0x9A, 0x1A, 0x6A, 0x4A, 0x5A on consecutive clocks -> request sequence 2, 4, 3, 1, 0. data_out matches each flit, the first request appears one clock after the first write, and no bubbles occur between flits.
- Grant hold: write 0x9A with grant=0 for 5 clocks -> request=2 and data_out=0x9A held stable throughout, count=1. Pulse grant for 1 clock -> pop; request=7 on the next clock.
- Full/back-pressure: grant=0, write 5 flits 0x11..0x15 -> full=1 after the 4th write, 0x15 is dropped, count=4. Then grant=1 -> outputs 0x11..0x14 in order and full deasserts after the first pop.
- Simultaneous push/pop at count=2 with grant=1 -> count stays 2 and the order is preserved.
- Reset mid-operation: 3 flits buffered in REQ, assert rst -> request=7 and count=0 without waiting for a clock edge. After release, the old flits never reappear.

Source files
------------

// File: rtl/noc_input_port.sv
// noc_input_port: per-direction input stage of a 5-port XY mesh router.
// Buffers upstream flits in a small FIFO, presents the head flit and its XY
// route code to the switch, and holds them until the switch grants.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   data_in   - flit from upstream
//   valid_in  - upstream write strobe (ignored while full)
//   full      - FIFO full, back-pressure to upstream
//   data_out  - head flit presented to the switch
//   request   - route code: 0 L, 1 N, 2 E, 3 S, 4 W, 7 none
//   grant     - switch grant for this port; pops the presented flit
//   count     - FIFO occupancy
module noc_input_port #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter logic [1:0]  X_CUR  = 2'd1,
  parameter logic [1:0]  Y_CUR  = 2'd1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     valid_in,
  output logic                     full,
  output logic [DATA_W-1:0]        data_out,
  output logic [2:0]               request,
  input  logic                     grant,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [2:0] ReqL    = 3'd0;
  localparam logic [2:0] ReqN    = 3'd1;
  localparam logic [2:0] ReqE    = 3'd2;
  localparam logic [2:0] ReqS    = 3'd3;
  localparam logic [2:0] ReqW    = 3'd4;
  localparam logic [2:0] ReqNone = 3'd7;

  typedef enum logic {StIdle, StReq} state_e;

  // XY routing: X dimension resolved before Y.
  function automatic logic [2:0] route(input logic [1:0] dx, input logic [1:0] dy);
    logic [2:0] code;
    if (dx > X_CUR)      code = ReqE;
    else if (dx < X_CUR) code = ReqW;
    else if (dy > Y_CUR) code = ReqS;
    else if (dy < Y_CUR) code = ReqN;
    else                 code = ReqL;
    return code;
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [CntW-1:0]   count_q, count_d;
  logic              full_q, full_d;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [2:0]        request_q, request_d;
  logic              push, pop;
  logic [DATA_W-1:0] head, next_head;

  assign push       = valid_in & ~full_q;
  assign pop        = (state_q == StReq) & grant;
  assign rd_ptr_nxt = rd_ptr_q + PtrW'(1);
  assign head       = mem_q[rd_ptr_q];
  assign next_head  = mem_q[rd_ptr_nxt];

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CntW'(DEPTH));
  end

  // The next head is only taken from flits already stored before this edge;
  // a flit pushed on the edge that pops the last one is presented via IDLE.
  always_comb begin
    state_d    = state_q;
    data_out_d = data_out_q;
    request_d  = request_q;
    unique case (state_q)
      StIdle: begin
        request_d = ReqNone;
        if (count_q != '0) begin
          data_out_d = head;
          request_d  = route(head[7:6], head[5:4]);
          state_d    = StReq;
        end
      end
      StReq: begin
        if (grant) begin
          if (count_q > CntW'(1)) begin
            data_out_d = next_head;
            request_d  = route(next_head[7:6], next_head[5:4]);
          end else begin
            request_d = ReqNone;
            state_d   = StIdle;
          end
        end
      end
      default: begin
        request_d = ReqNone;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      state_q    <= StIdle;
      data_out_q <= '0;
      request_q  <= ReqNone;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_nxt;
      count_q    <= count_d;
      full_q     <= full_d;
      state_q    <= state_d;
      data_out_q <= data_out_d;
      request_q  <= request_d;
    end
  end

  // Storage needs no reset; occupancy tracking makes stale entries invisible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  assign full     = full_q;
  assign data_out = data_out_q;
  assign request  = request_q;
  assign count    = count_q;

endmodule
